// File: rtl/spi_mst.sv
// rtl/spi_mst.sv - SPI register-access master, 24-bit CRC-protected frames with one-frame-delayed response
module spi_mst #(
  parameter int GAP_CYC = 20
) (
  input  logic       i_spi_sclk,
  input  logic       i_rst_n,
  input  logic       i_req,
  output logic       o_rdy,
  input  logic       i_wr,
  input  logic [6:0] i_addr,
  input  logic [7:0] i_wdata,
  output logic       o_spi_sclk,
  output logic       o_spi_csb,
  output logic       o_spi_mosi,
  input  logic       i_spi_miso,
  output logic       o_rsp_vld,
  output logic       o_rsp_status,
  output logic [6:0] o_rsp_addr,
  output logic [7:0] o_rsp_data,
  output logic       o_rsp_crc_err
);

  localparam int            GW       = $clog2(GAP_CYC + 1);
  localparam logic [GW-1:0] GAP_LAST = GW'(GAP_CYC - 1);

  typedef enum logic [2:0] {IDLE, SETUP, SHIFT, HOLD, GAP} state_t;

  state_t        state;
  state_t        state_nxt;
  logic [23:0]   tx_sr;
  logic [23:0]   rx_sr;
  logic [4:0]    bit_cnt;
  logic [GW-1:0] gap_cnt;
  logic          prev_frame;
  logic          gate;
  logic          frame_act;
  logic [7:0]    tx_data;
  logic [23:0]   tx_frame;

  // CRC-8, polynomial x^8+x^2+x+1, zero init, MSB first over 16 bits, unrolled into parallel logic
  function automatic logic [7:0] crc16to8_parallel(input logic [15:0] d);
    logic [7:0] c;
    logic       fb;
    c = 8'h00;
    for (int i = 15; i >= 0; i--) begin
      fb = c[7] ^ d[i];
      c  = {c[6:0], 1'b0} ^ (fb ? 8'h07 : 8'h00);
    end
    return c;
  endfunction

  assign tx_data   = i_wr ? i_wdata : 8'h00;
  assign tx_frame  = {i_wr, i_addr, tx_data, crc16to8_parallel({i_wr, i_addr, tx_data})};
  assign o_rdy     = (state == IDLE);
  assign frame_act = (state == SETUP) || (state == SHIFT) || (state == HOLD);
  // gate only changes while i_spi_sclk is low, so the AND cannot glitch
  assign o_spi_sclk = i_spi_sclk & gate;

  // state register
  always_ff @(posedge i_spi_sclk or negedge i_rst_n) begin
    if (!i_rst_n) state <= IDLE;
    else          state <= state_nxt;
  end

  // next-state: one setup cycle, 24 shift cycles, one hold cycle for the last miso bit, then the gap
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (i_req) state_nxt = SETUP;
      SETUP:   state_nxt = SHIFT;
      SHIFT:   if (bit_cnt == 5'd23) state_nxt = HOLD;
      HOLD:    state_nxt = GAP;
      GAP:     if (gap_cnt == GAP_LAST) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // frame shifting, miso capture and counters; last tx bit is held through the final gated cycle
  always_ff @(posedge i_spi_sclk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      tx_sr   <= '0;
      rx_sr   <= '0;
      bit_cnt <= '0;
      gap_cnt <= '0;
    end else begin
      if (state == IDLE && i_req)
        tx_sr <= tx_frame;
      else if (state == SHIFT && bit_cnt != 5'd23)
        tx_sr <= {tx_sr[22:0], 1'b0};

      if ((state == SHIFT && bit_cnt != 5'd0) || state == HOLD)
        rx_sr <= {rx_sr[22:0], i_spi_miso};

      if (state == SETUP)      bit_cnt <= '0;
      else if (state == SHIFT) bit_cnt <= bit_cnt + 5'd1;

      if (state == HOLD)     gap_cnt <= '0;
      else if (state == GAP) gap_cnt <= gap_cnt + 1'b1;
    end
  end

  // response decode on the first gap cycle; the first frame after reset has nothing to answer for
  always_ff @(posedge i_spi_sclk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      o_rsp_vld     <= 1'b0;
      o_rsp_status  <= 1'b0;
      o_rsp_addr    <= '0;
      o_rsp_data    <= '0;
      o_rsp_crc_err <= 1'b0;
      prev_frame    <= 1'b0;
    end else begin
      o_rsp_vld <= 1'b0;
      if (state == GAP && gap_cnt == '0) begin
        prev_frame <= 1'b1;
        if (prev_frame) begin
          o_rsp_vld     <= 1'b1;
          o_rsp_status  <= rx_sr[23];
          o_rsp_addr    <= rx_sr[22:16];
          o_rsp_data    <= rx_sr[15:8];
          o_rsp_crc_err <= (crc16to8_parallel(rx_sr[23:8]) != rx_sr[7:0]);
        end
      end
    end
  end

  // pin retiming on the falling edge so the slave sees stable data at each gated rising edge
  always_ff @(negedge i_spi_sclk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      o_spi_csb  <= 1'b1;
      o_spi_mosi <= 1'b0;
      gate       <= 1'b0;
    end else begin
      o_spi_csb  <= !frame_act;
      o_spi_mosi <= frame_act ? tx_sr[23] : 1'b0;
      gate       <= (state == SHIFT);
    end
  end

endmodule

// File: tb/tb_spi_mst.sv
// tb/tb_spi_mst.sv - table-driven bench for spi_mst with a register-file slave model
module tb_spi_mst;

  localparam int GAP_CYC = 20;

  logic       i_spi_sclk = 1'b0;
  logic       i_rst_n    = 1'b0;
  logic       i_req      = 1'b0;
  logic       i_wr       = 1'b0;
  logic [6:0] i_addr     = '0;
  logic [7:0] i_wdata    = '0;
  logic       i_spi_miso = 1'b0;
  logic       o_rdy, o_spi_sclk, o_spi_csb, o_spi_mosi;
  logic       o_rsp_vld, o_rsp_status, o_rsp_crc_err;
  logic [6:0] o_rsp_addr;
  logic [7:0] o_rsp_data;

  spi_mst #(.GAP_CYC(GAP_CYC)) dut (
    .i_spi_sclk   (i_spi_sclk),
    .i_rst_n      (i_rst_n),
    .i_req        (i_req),
    .o_rdy        (o_rdy),
    .i_wr         (i_wr),
    .i_addr       (i_addr),
    .i_wdata      (i_wdata),
    .o_spi_sclk   (o_spi_sclk),
    .o_spi_csb    (o_spi_csb),
    .o_spi_mosi   (o_spi_mosi),
    .i_spi_miso   (i_spi_miso),
    .o_rsp_vld    (o_rsp_vld),
    .o_rsp_status (o_rsp_status),
    .o_rsp_addr   (o_rsp_addr),
    .o_rsp_data   (o_rsp_data),
    .o_rsp_crc_err(o_rsp_crc_err)
  );

  always #5 i_spi_sclk = ~i_spi_sclk;

  typedef struct {
    logic       wr;
    logic [6:0] addr;
    logic [7:0] wdata;
    logic       flip;
    logic       exp_vld;
    logic       exp_st;
    logic [6:0] exp_addr;
    logic [7:0] exp_data;
    logic       exp_err;
  } vec_t;

  int n_vec = 0;
  int n_err = 0;

  // byte-at-a-time CRC-8 (poly 0x07, zero init)
  function automatic logic [7:0] crc_ref(input logic [15:0] d);
    logic [7:0] c;
    c = d[15:8];
    for (int i = 0; i < 8; i++) c = c[7] ? ({c[6:0], 1'b0} ^ 8'h07) : {c[6:0], 1'b0};
    c = c ^ d[7:0];
    for (int i = 0; i < 8; i++) c = c[7] ? ({c[6:0], 1'b0} ^ 8'h07) : {c[6:0], 1'b0};
    return c;
  endfunction

  function automatic logic [23:0] mk_frame(input logic wr, input logic [6:0] a, input logic [7:0] wd);
    logic [7:0] d;
    d = wr ? wd : 8'h00;
    return {wr, a, d, crc_ref({wr, a, d})};
  endfunction

  // monitors
  logic [23:0] mon_sr = '0;
  int gclk_total = 0;
  int sneg_total = 0;
  int vld_total  = 0;
  int bad_sclk   = 0;
  int hi_run     = 0;
  int rdy_run    = 0;
  int last_hi    = 0;
  int last_rdy   = 0;

  always @(posedge o_spi_sclk) begin
    mon_sr = {mon_sr[22:0], o_spi_mosi};
    gclk_total++;
    if (o_spi_csb) bad_sclk++;
  end

  always @(negedge i_spi_sclk) if (o_rsp_vld) vld_total++;

  always @(posedge i_spi_sclk) hi_run = o_spi_csb ? hi_run + 1 : 0;
  always @(negedge i_spi_sclk) rdy_run = o_spi_csb ? rdy_run + (o_rdy ? 1 : 0) : 0;
  always @(negedge o_spi_csb) begin
    last_hi  = hi_run;
    last_rdy = rdy_run;
  end

  // slave: answers each frame with {was_write, addr, data, crc} of the frame before it
  logic [7:0]  mem [0:127] = '{default: 8'h00};
  logic [23:0] slv_next = '0;
  logic [23:0] slv_word = '0;
  logic        flip = 1'b0;
  int          nbase = 0;
  int          pbase = 0;
  logic        s_wr;
  logic [6:0]  s_a;
  logic [7:0]  s_d;

  always @(negedge o_spi_csb) begin
    slv_word = slv_next ^ {23'b0, flip};
    nbase    = sneg_total;
    pbase    = gclk_total;
  end

  always @(negedge o_spi_sclk) begin
    if (sneg_total - nbase < 24) i_spi_miso = slv_word[23 - (sneg_total - nbase)];
    sneg_total++;
  end

  always @(posedge o_spi_csb) begin
    if (gclk_total - pbase == 24) begin
      s_wr = mon_sr[23];
      s_a  = mon_sr[22:16];
      if (s_wr) mem[s_a] = mon_sr[15:8];
      s_d      = mem[s_a];
      slv_next = {s_wr, s_a, s_d, crc_ref({s_wr, s_a, s_d})};
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge i_spi_sclk);
    #2;
  endtask

  task automatic do_frame(input vec_t v, input bit hold, input string tag, output logic [23:0] cap);
    int  base_g, base_v;
    bit  ok;
    cap = '0;
    tick();
    i_wr = v.wr; i_addr = v.addr; i_wdata = v.wdata; flip = v.flip; i_req = 1'b1;
    ok = 0;
    for (int k = 0; k < 200 && !ok; k++) begin
      if (o_rdy) ok = 1;
      else tick();
    end
    chk({tag, "_accept_timeout"}, ok, 1);
    if (!ok) begin
      i_req = 1'b0;
      return;
    end
    base_g = gclk_total;
    base_v = vld_total;
    tick();
    if (!hold) i_req = 1'b0;
    chk({tag, "_rdy_low"}, o_rdy, 0);
    ok = 0;
    for (int k = 0; k < 10 && !ok; k++) begin
      tick();
      if (!o_spi_csb) ok = 1;
    end
    chk({tag, "_csb_fall_timeout"}, ok, 1);
    ok = 0;
    for (int k = 0; k < 40 && !ok; k++) begin
      tick();
      if (o_spi_csb) ok = 1;
    end
    chk({tag, "_csb_rise_timeout"}, ok, 1);
    tick();
    cap = mon_sr;
    chk({tag, "_gated_edges"}, gclk_total - base_g, 24);
    chk({tag, "_mosi_frame"}, mon_sr, mk_frame(v.wr, v.addr, v.wdata));
    chk({tag, "_vld_pulses"}, vld_total - base_v, v.exp_vld);
    if (v.exp_vld) begin
      chk({tag, "_status"}, o_rsp_status, v.exp_st);
      chk({tag, "_addr"}, o_rsp_addr, v.exp_addr);
      chk({tag, "_data"}, o_rsp_data, v.exp_data);
      chk({tag, "_crc_err"}, o_rsp_crc_err, v.exp_err);
    end
  endtask

  vec_t        vecs [10];
  vec_t        v;
  logic [23:0] cap;
  bit          ok;

  initial begin
    //         wr    addr   wdata  flip  vld   st    addr   data   err
    vecs[0] = '{1'b1, 7'h15, 8'hA5, 1'b0, 1'b0, 1'b0, 7'h00, 8'h00, 1'b0};
    vecs[1] = '{1'b1, 7'h15, 8'hA5, 1'b0, 1'b1, 1'b1, 7'h15, 8'hA5, 1'b0};
    vecs[2] = '{1'b0, 7'h15, 8'h00, 1'b1, 1'b1, 1'b1, 7'h15, 8'hA5, 1'b1};
    vecs[3] = '{1'b0, 7'h15, 8'h77, 1'b0, 1'b1, 1'b0, 7'h15, 8'hA5, 1'b0};
    vecs[4] = '{1'b1, 7'h2A, 8'h3C, 1'b0, 1'b1, 1'b0, 7'h15, 8'hA5, 1'b0};
    vecs[5] = '{1'b0, 7'h2A, 8'h00, 1'b0, 1'b1, 1'b1, 7'h2A, 8'h3C, 1'b0};
    vecs[6] = '{1'b0, 7'h00, 8'h00, 1'b0, 1'b1, 1'b0, 7'h2A, 8'h3C, 1'b0};
    vecs[7] = '{1'b1, 7'h7F, 8'hFF, 1'b0, 1'b1, 1'b0, 7'h00, 8'h00, 1'b0};
    vecs[8] = '{1'b0, 7'h7F, 8'h00, 1'b1, 1'b1, 1'b1, 7'h7F, 8'hFF, 1'b1};
    vecs[9] = '{1'b0, 7'h7F, 8'h00, 1'b0, 1'b1, 1'b0, 7'h7F, 8'hFF, 1'b0};

    // reset state
    #23;
    chk("rst_csb", o_spi_csb, 1);
    chk("rst_sclk", o_spi_sclk, 0);
    chk("rst_mosi", o_spi_mosi, 0);
    chk("rst_vld", o_rsp_vld, 0);
    chk("rst_data", o_rsp_data, 0);
    tick();
    i_rst_n = 1'b1;
    tick();
    chk("rst_rdy", o_rdy, 1);

    for (int i = 0; i < 10; i++) begin
      do_frame(vecs[i], 0, $sformatf("v%0d", i), cap);
      if (i == 0) chk("v0_hand_frame", cap, 24'h95A5D2);
    end

    // back-to-back with the request held: gap length and o_rdy during the gap
    v = '{1'b1, 7'h10, 8'h11, 1'b0, 1'b1, 1'b0, 7'h7F, 8'hFF, 1'b0};
    do_frame(v, 1, "gap1", cap);
    ok = 0;
    for (int k = 0; k < 60 && !ok; k++) begin
      tick();
      if (!o_spi_csb) ok = 1;
    end
    i_req = 1'b0;
    chk("gap_refire_timeout", ok, 1);
    // csb rises at N26; posedges P27..P26+GAP_CYC plus the accepting posedge see csb high
    chk("gap_high_posedges", last_hi, GAP_CYC + 1);
    chk("gap_rdy_negedges", last_rdy, 1);
    ok = 0;
    for (int k = 0; k < 60 && !ok; k++) begin
      tick();
      if (o_spi_csb) ok = 1;
    end
    chk("gap2_done_timeout", ok, 1);

    // reset pulse at P10 of a write frame
    tick();
    i_wr = 1'b1; i_addr = 7'h55; i_wdata = 8'h5A; flip = 1'b0; i_req = 1'b1;
    ok = 0;
    for (int k = 0; k < 200 && !ok; k++) begin
      if (o_rdy) ok = 1;
      else tick();
    end
    chk("abort_accept_timeout", ok, 1);
    repeat (11) @(posedge i_spi_sclk);
    i_req = 1'b0;
    #2 i_rst_n = 1'b0;
    #1;
    chk("abort_csb", o_spi_csb, 1);
    chk("abort_sclk", o_spi_sclk, 0);
    chk("abort_mosi", o_spi_mosi, 0);
    chk("abort_rsp_addr", o_rsp_addr, 0);
    @(negedge i_spi_sclk);
    i_rst_n = 1'b1;
    tick();
    chk("abort_rdy", o_rdy, 1);
    v = '{1'b0, 7'h55, 8'h00, 1'b0, 1'b0, 1'b0, 7'h00, 8'h00, 1'b0};
    do_frame(v, 0, "post_rst1", cap);
    v = '{1'b0, 7'h00, 8'h00, 1'b0, 1'b1, 1'b0, 7'h55, 8'h00, 1'b0};
    do_frame(v, 0, "post_rst2", cap);

    chk("sclk_while_csb_high", bad_sclk, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/spi_mst.md
SPI_MST -- requirements
Module: spi_mst

Interface
REQ-001 SHALL have parameter: GAP_CYC, 20, minimum i_spi_sclk cycles with o_spi_csb high between frames.
REQ-002 SHALL have ports:
- i_spi_sclk, in, 1: clock, free-running bit clock.
- i_rst_n, in, 1: reset, asynchronous, active-low.
- i_req, in, 1: access request.
- o_rdy, out, 1: request accepted when i_req & o_rdy at posedge.
- i_wr, in, 1: 1 = write, 0 = read.
- i_addr, in, 7: register address.
- i_wdata, in, 8: write data, ignored on read.
- o_spi_sclk, out, 1: gated SPI clock.
- o_spi_csb, out, 1: chip select, active-low.
- o_spi_mosi, out, 1: serial data out, MSB first.
- i_spi_miso, in, 1: serial data in.
- o_rsp_vld, out, 1: one-cycle response strobe.
- o_rsp_status, out, 1: miso bit 23; 1 = previous frame was a write.
- o_rsp_addr, out, 7: echoed address.
- o_rsp_data, out, 8: returned data.
- o_rsp_crc_err, out, 1: response CRC mismatch.

Function
REQ-003 SHALL clock control, handshake and miso capture on posedge i_spi_sclk.
REQ-004 SHALL retime o_spi_csb, o_spi_mosi and sclk gate-enable on negedge i_spi_sclk from posedge-domain values.
REQ-005 SHALL drive o_spi_sclk = i_spi_sclk AND gate-enable, so the gated clock is glitch-free.
REQ-006 SHALL define the frame as 24 bits: {i_wr, i_addr[6:0], D[7:0], C[7:0]}.
- D = i_wdata on write, 8'h00 on read.
- C = crc16to8_parallel({i_wr, i_addr, D}).
REQ-007 SHALL implement FSM states IDLE, SETUP, SHIFT, HOLD, GAP.
- o_rdy = (state == IDLE).
- Timeline indices P0 = accepting posedge, Pk/Nk = k-th posedge/negedge after P0.
REQ-008 SHALL on acceptance at P0: latch the frame into the tx shift register; IDLE -> SETUP.
REQ-009 SHALL at N0: drive o_spi_csb = 0 and o_spi_mosi = frame bit 23, with gate still 0.
REQ-010 SHALL set gate = 1 at N1, giving exactly 24 gated posedges P2..P25.
REQ-011 SHALL update o_spi_mosi at N2..N24 with frame bits 22..0.
REQ-012 SHALL clear gate at N25.
REQ-013 SHALL capture i_spi_miso at P3..P26 into a 24-bit rx shift register, MSB first; P26 falls within HOLD with csb still low.
REQ-014 SHALL drive o_spi_csb = 1 and o_spi_mosi = 0 at N26; FSM enters GAP at P26.
REQ-015 SHALL hold o_spi_csb high for GAP_CYC posedges (P27..P26+GAP_CYC), then return to IDLE; o_rdy = 0 throughout GAP.
REQ-016 SHALL decode the response at P27 from rx bits R[23:0]:
- o_rsp_status = R[23]
- o_rsp_addr = R[22:16]
- o_rsp_data = R[15:8]
- o_rsp_crc_err = (crc16to8_parallel(R[23:8]) != R[7:0])
REQ-017 SHALL treat the response as belonging to the PREVIOUS frame; read data requires a following frame.
REQ-018 SHALL pulse o_rsp_vld for exactly one cycle after P27, only if a complete frame preceded the current one since reset.
REQ-019 SHALL hold o_rsp_* fields stable until the next o_rsp_vld.
REQ-020 SHALL ignore i_req while o_rdy = 0; no queuing, and a held request is accepted on the first IDLE posedge.
REQ-021 SHALL keep o_spi_sclk low whenever o_spi_csb is high.
REQ-022 SHALL implement the gap counter with width $clog2(GAP_CYC+1), saturate-free, cleared on GAP entry.

Reset
REQ-023 SHALL on i_rst_n low, immediately and asynchronously:
- o_spi_csb = 1, gate = 0, o_spi_mosi = 0
- state = IDLE, o_rdy = 1 after release
- o_rsp_vld = 0, o_rsp_* = 0
- previous-frame flag = 0
REQ-024 SHALL abort an in-flight frame on reset mid-operation; the first frame after reset produces no o_rsp_vld.

Verification
REQ-025 SHALL cover these scenarios:
- Reset: assert i_rst_n = 0 -> csb = 1, sclk = 0, mosi = 0, o_rdy = 1 after release, o_rsp_vld = 0.
- First frame, write addr 0x15 data 0xA5 -> mosi = {0x95, 0xA5, crc16to8(16'h95A5)}, 24 gated posedges, csb low N0..N26, no o_rsp_vld.
- Follow-up read addr 0x15, slave model returns {1, 0x15, 0xA5, crc} -> o_rsp_vld at P27 with status = 1, addr = 0x15, data = 0xA5, crc_err = 0.
- Same read with slave flipping R[0] -> o_rsp_crc_err = 1, other fields unchanged.
- GAP_CYC = 20, i_req held high -> next csb fall no earlier than 20 posedges after csb rise; o_rdy = 0 during gap.
- Reset pulse at P10 -> csb high at once, sclk stops, next frame gives no o_rsp_vld.
